// File: rtl/mux4to1_rr_sched.sv
// mux4to1_rr_sched: round-robin owner of one shared 4:1 data mux.
// A winner keeps the mux for QUANTUM accepted beats while others wait.
module mux4to1_rr_sched #(
  parameter int DATA_W  = 8,
  parameter int QUANTUM = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req,
  input  logic [4*DATA_W-1:0] in_data,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  output logic [3:0]          gnt,
  output logic [1:0]          sel,
  output logic [3:0]          ack
);

  localparam int CW = $clog2(QUANTUM + 1);
  localparam logic [CW-1:0] QMAX = CW'(QUANTUM - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t        state;
  logic [1:0]    lg;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          xfer;
  logic [3:0]    others;
  logic [1:0]    win;
  logic [1:0]    idx;
  logic          found;

  assign busy = (state == BUSY);

  // Mux path and handshake; everything is quiet while rst is high.
  always_comb begin
    out_valid = busy & req[sel] & ~rst;
    out_data  = '0;
    if (busy && !rst)
      out_data = in_data[int'(sel)*DATA_W +: DATA_W];
    xfer   = out_valid & out_ready;
    ack    = xfer ? (4'b0001 << sel) : 4'b0000;
    others = req & ~(4'b0001 << sel);
  end

  // Pick the first requester after the last grant, wrapping to lg.
  always_comb begin
    win   = lg;
    idx   = lg;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = lg + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Grant FSM: quantum counts accepted beats only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      lg    <= 2'd3;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            gnt   <= 4'b0001 << win;
            sel   <= win;
            lg    <= win;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!req[sel]) begin
            gnt   <= '0;
            cnt   <= '0;
            state <= IDLE;
          end else if (xfer) begin
            if (cnt == QMAX) begin
              cnt <= '0;
              if (|others) begin
                gnt   <= '0;
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          gnt   <= '0;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4to1_rr_sched.sv
// tb_mux4to1_rr_sched: directed vector table plus random traffic
// against a beat-counting reference model.
module tb_mux4to1_rr_sched;

  localparam int DW = 8;
  localparam int Q  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req;
  logic [4*DW-1:0] in_data;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic [3:0]      gnt;
  logic [1:0]      sel;
  logic [3:0]      ack;

  mux4to1_rr_sched #(
    .DATA_W (DW),
    .QUANTUM(Q)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .in_data  (in_data),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .gnt      (gnt),
    .sel      (sel),
    .ack      (ack)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit m_busy;
  int m_own;
  int m_sel;
  int m_lg;
  int m_beats;

  typedef struct {
    logic       r;
    logic [3:0] q;
    logic       rdy;
    logic [3:0] g;
    logic       v;
    logic [3:0] a;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic [3:0] q, logic rdy,
                              logic [3:0] g, logic v, logic [3:0] a);
    vec_t e;
    e.r = r; e.q = q; e.rdy = rdy;
    e.g = g; e.v = v; e.a = a;
    tbl.push_back(e);
  endfunction

  function automatic void m_reset();
    m_busy  = 1'b0;
    m_own   = 0;
    m_sel   = 0;
    m_lg    = 3;
    m_beats = 0;
  endfunction

  function automatic logic [DW-1:0] word(int i);
    return in_data[i*DW +: DW];
  endfunction

  task automatic check_model();
    logic [3:0]    e_gnt;
    logic [1:0]    e_sel;
    logic          e_val;
    logic [DW-1:0] e_dat;
    logic [3:0]    e_ack;
    logic [18:0]   got;
    logic [18:0]   exp_v;
    e_gnt = m_busy ? 4'(1 << m_own) : 4'b0;
    e_sel = 2'(m_sel);
    e_val = !rst && m_busy && req[m_own];
    e_dat = (m_busy && !rst) ? word(m_own) : '0;
    e_ack = (e_val && out_ready) ? 4'(1 << m_own) : 4'b0;
    got   = {gnt, sel, out_valid, out_data, ack};
    exp_v = {e_gnt, e_sel, e_val, e_dat, e_ack};
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL model t=%0t gnt/sel/vld/data/ack got %h %h %b %h %h want %h %h %b %h %h",
               $time, gnt, sel, out_valid, out_data, ack,
               e_gnt, e_sel, e_val, e_dat, e_ack);
    end
  endtask

  task automatic m_step();
    int idx;
    if (rst) begin
      m_reset();
    end else if (!m_busy) begin
      if (req != 4'b0) begin
        for (int k = 1; k <= 4; k++) begin
          idx = (m_lg + k) % 4;
          if (!m_busy && req[idx]) begin
            m_busy  = 1'b1;
            m_own   = idx;
            m_sel   = idx;
            m_lg    = idx;
            m_beats = 0;
          end
        end
      end
    end else if (!req[m_own]) begin
      m_busy  = 1'b0;
      m_beats = 0;
    end else if (out_ready) begin
      m_beats++;
      if (m_beats == Q) begin
        m_beats = 0;
        if ((req & ~4'(1 << m_own)) != 4'b0)
          m_busy = 1'b0;
      end
    end
  endtask

  task automatic cyc_edge();
    @(posedge clk);
    m_step();
    #1;
  endtask

  initial begin
    m_reset();
    rst       = 1'b1;
    req       = 4'b0;
    out_ready = 1'b1;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    cyc_edge();

    add(1, 4'hF, 1, 4'h0, 0, 4'h0);
    add(1, 4'hF, 1, 4'h0, 0, 4'h0);
    add(0, 4'hF, 1, 4'h0, 0, 4'h0);
    for (int i = 0; i < 4; i++) add(0, 4'hF, 1, 4'h1, 1, 4'h1);
    add(0, 4'hF, 1, 4'h0, 0, 4'h0);
    for (int i = 0; i < 4; i++) add(0, 4'hF, 1, 4'h2, 1, 4'h2);
    add(1, 4'hF, 1, 4'h0, 0, 4'h0);
    add(0, 4'h2, 1, 4'h0, 0, 4'h0);
    add(0, 4'h3, 1, 4'h2, 1, 4'h2);
    add(0, 4'h3, 0, 4'h2, 1, 4'h0);
    add(0, 4'h3, 0, 4'h2, 1, 4'h0);
    for (int i = 0; i < 3; i++) add(0, 4'h3, 1, 4'h2, 1, 4'h2);
    add(0, 4'h3, 1, 4'h0, 0, 4'h0);
    add(0, 4'h3, 1, 4'h1, 1, 4'h1);
    add(0, 4'h8, 1, 4'h1, 0, 4'h0);
    add(0, 4'h9, 1, 4'h0, 0, 4'h0);
    add(0, 4'h9, 1, 4'h8, 1, 4'h8);
    add(0, 4'h9, 1, 4'h8, 1, 4'h8);
    add(0, 4'h1, 1, 4'h8, 0, 4'h0);
    add(0, 4'h1, 1, 4'h0, 0, 4'h0);
    add(0, 4'h1, 1, 4'h1, 1, 4'h1);
    add(1, 4'h1, 1, 4'h1, 0, 4'h0);
    add(0, 4'h0, 1, 4'h0, 0, 4'h0);
    add(0, 4'h9, 1, 4'h0, 0, 4'h0);
    add(0, 4'h4, 1, 4'h1, 0, 4'h0);
    add(0, 4'h4, 1, 4'h0, 0, 4'h0);
    for (int i = 0; i < 10; i++) add(0, 4'h4, 1, 4'h4, 1, 4'h4);
    add(0, 4'h0, 1, 4'h4, 0, 4'h0);

    foreach (tbl[i]) begin
      rst       = tbl[i].r;
      req       = tbl[i].q;
      out_ready = tbl[i].rdy;
      if (tbl[i].q == 4'h4)
        in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
      @(negedge clk);
      check_model();
      n_tests++;
      if ({gnt, out_valid, ack} !== {tbl[i].g, tbl[i].v, tbl[i].a}) begin
        n_fail++;
        $display("FAIL vec%0d gnt/vld/ack got %h %b %h want %h %b %h",
                 i, gnt, out_valid, ack, tbl[i].g, tbl[i].v, tbl[i].a);
      end
      if (tbl[i].q == 4'h4 && tbl[i].v) begin
        n_tests++;
        if (out_data !== 8'hA5) begin
          n_fail++;
          $display("FAIL sole_data got %h want a5", out_data);
        end
      end
      cyc_edge();
    end

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) < 3)
        req = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom};
      @(negedge clk);
      check_model();
      cyc_edge();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
